shift_add_multiplier: RTL
=========================

Name: shift_add_multiplier

Overview:
- Multi-cycle unsigned BITS x BITS multiplier built around one existing RippleCarryAdder instance.
- The block is the adder's sequencer: it drives the adder for one partial-product accumulate per clock, then shifts the result.
- It sits beside the accumulator datapath as an optional multiply unit for extended instructions.
- Start/busy/done handshake to the control unit.

Parameters:
- BITS, 16, operand width; product is 2*BITS; must be >= 2.

Ports:
- clk_in  input  1  clock, rising edge.
- rst_n_in  input  1  asynchronous, active-low reset.
- start_in  input  1  request; sampled only in IDLE.
- a_in  input  BITS  multiplicand; captured when start is accepted.
- b_in  input  BITS  multiplier; captured when start is accepted.
- busy_out  output  1  high while state != IDLE.
- done_out  output  1  one-cycle pulse; product_out valid from this cycle on.
- product_out  output  2*BITS  unsigned a*b; held until the next accepted start.

Behaviour:
- Reset (asynchronous assert, rst_n_in low):
  - state=IDLE; busy_out=0, done_out=0, product_out=0.
  - All internal registers (mcand, acc, carry, q, count) are cleared.
  - Asserting reset mid-operation aborts it with no partial result visible.
- States: IDLE, RUN, DONE.
  - IDLE -> RUN: on an edge with start_in=1.
    - mcand<=a_in, q<=b_in, acc<=0, count<=0, product_out<=0.
  - RUN: one iteration per clock.
    - Adder inputs: a=acc; b=(q[0] ? mcand : 0); carry-in=0.
    - On the edge: {acc, q} <= {c_out, sum, q} >> 1, a (2*BITS+1)-bit right shift; count<=count+1.
  - RUN -> DONE: on the edge where count==BITS-1. product_out <= the shifted {acc, q} value.
  - DONE: done_out=1 for exactly this one cycle; -> IDLE on the next edge unconditionally.
- Latency:
  - start sampled at edge E0.
  - RUN spans BITS cycles; done_out is high in the cycle after edge E0+BITS.
  - 17 cycles for BITS=16.
- Handshake:
  - start_in is ignored while busy_out=1, including the DONE cycle.
  - A new start is accepted the cycle after DONE (IDLE), so back-to-back throughput is one result per BITS+2 cycles.
  - start_in held high continuously re-triggers at every IDLE.
- Operands: a_in/b_in changing after acceptance has no effect.
- Widths:
  - Adder carry-out feeds the shift; no overflow is possible.
  - Max product (2^BITS-1)^2 fits in 2*BITS bits.
- Zero operands still take the full BITS iterations; there is no early exit.
- done_out and busy_out are registered/state-decoded only, with no combinational path from inputs.

Decomposition:
- Shared package mult_pkg:
  - state enum (IDLE, RUN, DONE, 2-bit encoding).
  - Count-width function $clog2(BITS)+1.
- Sub-module: instantiate the existing RippleCarryAdder (BITS) for the accumulate. Do not inline a "+".
- Everything else (FSM, counter, shift registers) stays in shift_add_multiplier.

Test Plan:
- 0x0000 x 0x1234 -> product_out=0x00000000, done_out pulse 17 cycles after start, busy_out high for 17 cycles.
- 0xFFFF x 0xFFFF -> 0xFFFE0001. Then a start in the first IDLE cycle with 0xAE43 x 0x0002 -> 0x00015C86; first product held until second accepted.
- 0x1234 x 0x5678 -> 0x06260060. start_in pulsed again with 0x0001 x 0x0001 at cycles 5 and 16 (DONE) -> ignored, result unchanged, single done_out pulse.
- rst_n_in driven low at cycle 8 of 0xAE43 x 0x00FF -> outputs 0 immediately (asynchronous). After release, 0x0003 x 0x0005 -> 0x0000000F with normal 17-cycle latency.
- a_in/b_in toggled every cycle after start of 0x8000 x 0x0002 -> product 0x00010000, unaffected.
- start_in held high for 60 cycles with 0x0010 x 0x0010 -> done_out every 18 cycles, product 0x00000100 each time.

Source files
------------

// File: rtl/mult_pkg.sv
// -----------------------------------------------------------------------------
// mult_pkg : shared types/helpers for the shift-add multiplier   (rev 1.0)
// -----------------------------------------------------------------------------
`default_nettype none

package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Iteration counter must reach BITS, hence the extra bit.
  function automatic int cnt_width(input int bits);
    return $clog2(bits) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/RippleCarryAdder.sv
// -----------------------------------------------------------------------------
// RippleCarryAdder : BITS-wide ripple-carry adder with carry in/out   (rev 1.0)
// -----------------------------------------------------------------------------
`default_nettype none

module RippleCarryAdder #(
  parameter int BITS = 16
) (
  input  logic [BITS-1:0] i_a,
  input  logic [BITS-1:0] i_b,
  input  logic            i_cin,
  output logic [BITS-1:0] o_sum,
  output logic            o_cout
);

  logic [BITS:0] w_c;

  assign w_c[0] = i_cin;

  genvar i;
  for (i = 0; i < BITS; i++) begin : g_bit
    assign o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
    assign w_c[i+1]  = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
  end

  assign o_cout = w_c[BITS];

endmodule

`default_nettype wire

// File: rtl/shift_add_multiplier.sv
// -----------------------------------------------------------------------------
// shift_add_multiplier : sequential unsigned BITS x BITS shift-add multiplier (rev 1.0)
// -----------------------------------------------------------------------------
`default_nettype none

module shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int BITS = 16
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              start_in,
  input  logic [BITS-1:0]   a_in,
  input  logic [BITS-1:0]   b_in,
  output logic              busy_out,
  output logic              done_out,
  output logic [2*BITS-1:0] product_out
);

  localparam int CW = cnt_width(BITS);

  state_t            r_state;
  state_t            w_next;
  logic [BITS-1:0]   r_mcand;
  logic [BITS-1:0]   r_acc;
  logic [BITS-1:0]   r_q;
  logic [CW-1:0]     r_count;
  logic [BITS-1:0]   w_addend;
  logic [BITS-1:0]   w_sum;
  logic              w_cout;
  logic [2*BITS-1:0] w_shift;
  logic              w_last;

  assign w_addend = r_q[0] ? r_mcand : '0;
  assign w_last   = (r_count == CW'(BITS - 1));
  // {cout, sum, q} >> 1 : the LSB of q has been consumed, carry re-enters at the top.
  assign w_shift  = {w_cout, w_sum, r_q[BITS-1:1]};

  RippleCarryAdder #(.BITS(BITS)) u_adder (
    .i_a    (r_acc),
    .i_b    (w_addend),
    .i_cin  (1'b0),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start_in) w_next = RUN;
      RUN:     if (w_last)   w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_mcand     <= '0;
      r_acc       <= '0;
      r_q         <= '0;
      r_count     <= '0;
      product_out <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start_in) begin
            r_mcand     <= a_in;
            r_q         <= b_in;
            r_acc       <= '0;
            r_count     <= '0;
            product_out <= '0;
          end
        end
        RUN: begin
          r_acc   <= w_shift[2*BITS-1:BITS];
          r_q     <= w_shift[BITS-1:0];
          r_count <= r_count + CW'(1);
          if (w_last) product_out <= w_shift;
        end
        default: ;
      endcase
    end
  end

  assign busy_out = (r_state != IDLE);
  assign done_out = (r_state == DONE);

endmodule

`default_nettype wire
